// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one single-port memory between core and loader
module mem_arbiter #(
  parameter int LATENCY = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_0,
  input  logic          we_0,
  input  logic [AW-1:0] addr_0,
  input  logic [DW-1:0] wdata_0,
  output logic          done_0,
  output logic [DW-1:0] rdata_0,
  input  logic          req_1,
  input  logic          we_1,
  input  logic [AW-1:0] addr_1,
  input  logic [DW-1:0] wdata_1,
  output logic          done_1,
  output logic [DW-1:0] rdata_1,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output logic          busy,
  output logic          owner
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          last;
  logic          owner_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_0_q;
  logic [DW-1:0] rdata_1_q;
  logic          grant;
  logic          grant_port;
  logic          access_end;

  // On a tie the port that did not finish last wins, giving strict alternation.
  always_comb begin
    grant      = req_0 | req_1;
    grant_port = (req_0 && req_1) ? ~last : req_1;
    access_end = (state == ACCESS) && (cnt == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = ACCESS;
      ACCESS:  if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      last      <= 1'b1;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_0_q <= '0;
      rdata_1_q <= '0;
    end else begin
      if (state == IDLE && grant) begin
        owner_q <= grant_port;
        we_q    <= grant_port ? we_1 : we_0;
        addr_q  <= grant_port ? addr_1 : addr_0;
        wdata_q <= grant_port ? wdata_1 : wdata_0;
        cnt     <= CNT_INIT;
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      // Read data is taken on the last access cycle, only into the owner's register.
      if (access_end) begin
        last <= owner_q;
        if (!we_q) begin
          if (owner_q) rdata_1_q <= mem_rd;
          else         rdata_0_q <= mem_rd;
        end
      end
    end
  end

  always_comb begin
    busy   = (state != IDLE);
    mem_we = (state == ACCESS) && (cnt == CNT_INIT) && we_q;
    done_0 = (state == DONE) && !owner_q;
    done_1 = (state == DONE) && owner_q;
  end

  assign mem_adr = addr_q;
  assign mem_wd  = wdata_q;
  assign owner   = owner_q;
  assign rdata_0 = rdata_0_q;
  assign rdata_1 = rdata_1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter at LATENCY 1 and 3
module tb_mem_arbiter;

  typedef struct packed {
    logic        port;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        reset_a, a_req_0, a_we_0, a_req_1, a_we_1;
  logic [31:0] a_addr_0, a_wdata_0, a_addr_1, a_wdata_1;
  logic        a_done_0, a_done_1, a_mem_we, a_busy, a_owner;
  logic [31:0] a_rdata_0, a_rdata_1, a_mem_adr, a_mem_wd, a_mem_rd;

  logic        reset_b, b_req_0, b_we_0, b_req_1, b_we_1;
  logic [31:0] b_addr_0, b_wdata_0, b_addr_1, b_wdata_1;
  logic        b_done_0, b_done_1, b_mem_we, b_busy, b_owner;
  logic [31:0] b_rdata_0, b_rdata_1, b_mem_adr, b_mem_wd, b_mem_rd;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] exp_a_rd0 = 0, exp_a_rd1 = 0, exp_b_rd0 = 0, exp_b_rd1 = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hDEADBEEF;
      32'h20:  return 32'hA5A5A5A5;
      default: return a ^ 32'hC0DE0000;
    endcase
  endfunction

  function automatic exp_t mk(input logic p, input logic [31:0] r0, input logic [31:0] r1);
    exp_t e;
    e.port = p;
    e.rd0  = r0;
    e.rd1  = r1;
    return e;
  endfunction

  assign a_mem_rd = mem_f(a_mem_adr);
  assign b_mem_rd = mem_f(b_mem_adr);

  mem_arbiter #(.LATENCY(1), .AW(32), .DW(32)) dut_a (
    .clk(clk), .reset(reset_a),
    .req_0(a_req_0), .we_0(a_we_0), .addr_0(a_addr_0), .wdata_0(a_wdata_0),
    .done_0(a_done_0), .rdata_0(a_rdata_0),
    .req_1(a_req_1), .we_1(a_we_1), .addr_1(a_addr_1), .wdata_1(a_wdata_1),
    .done_1(a_done_1), .rdata_1(a_rdata_1),
    .mem_adr(a_mem_adr), .mem_wd(a_mem_wd), .mem_we(a_mem_we), .mem_rd(a_mem_rd),
    .busy(a_busy), .owner(a_owner)
  );

  mem_arbiter #(.LATENCY(3), .AW(32), .DW(32)) dut_b (
    .clk(clk), .reset(reset_b),
    .req_0(b_req_0), .we_0(b_we_0), .addr_0(b_addr_0), .wdata_0(b_wdata_0),
    .done_0(b_done_0), .rdata_0(b_rdata_0),
    .req_1(b_req_1), .we_1(b_we_1), .addr_1(b_addr_1), .wdata_1(b_wdata_1),
    .done_1(b_done_1), .rdata_1(b_rdata_1),
    .mem_adr(b_mem_adr), .mem_wd(b_mem_wd), .mem_we(b_mem_we), .mem_rd(b_mem_rd),
    .busy(b_busy), .owner(b_owner)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every done pulse must match the next queued completion.
  always @(negedge clk) begin
    if (reset_a && (a_done_0 || a_done_1)) begin
      chk("a_done_onehot", {31'd0, a_done_0 & a_done_1}, 32'd0);
      if (qa.size() == 0) begin
        chk("a_spurious_done", {30'd0, a_done_1, a_done_0}, 32'd0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_done_port", {31'd0, a_done_1}, {31'd0, e.port});
        chk("a_owner_at_done", {31'd0, a_owner}, {31'd0, e.port});
        chk("a_rdata_0", a_rdata_0, e.rd0);
        chk("a_rdata_1", a_rdata_1, e.rd1);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_b && (b_done_0 || b_done_1)) begin
      chk("b_done_onehot", {31'd0, b_done_0 & b_done_1}, 32'd0);
      if (qb.size() == 0) begin
        chk("b_spurious_done", {30'd0, b_done_1, b_done_0}, 32'd0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_done_port", {31'd0, b_done_1}, {31'd0, e.port});
        chk("b_owner_at_done", {31'd0, b_owner}, {31'd0, e.port});
        chk("b_rdata_0", b_rdata_0, e.rd0);
        chk("b_rdata_1", b_rdata_1, e.rd1);
      end
    end
  end

  // Counts negedges from the drive point until the selected done of dut_b.
  task automatic b_wait_done(input logic port, output int at);
    at = 0;
    for (int k = 1; k <= 12 && at == 0; k++) begin
      @(negedge clk);
      if (port ? b_done_1 : b_done_0) at = k;
    end
  endtask

  initial begin
    int seen, cyc, last_cyc, lowcnt, we_cnt, we_at, acc_cnt, done_at, at;

    reset_a = 0; reset_b = 0;
    {a_req_0, a_we_0, a_req_1, a_we_1} = '0;
    {b_req_0, b_we_0, b_req_1, b_we_1} = '0;
    a_addr_0 = 0; a_wdata_0 = 0; a_addr_1 = 0; a_wdata_1 = 0;
    b_addr_0 = 0; b_wdata_0 = 0; b_addr_1 = 0; b_wdata_1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("a_rst_ctrl", {27'd0, a_done_0, a_done_1, a_mem_we, a_busy, a_owner}, 32'd0);
    chk("a_rst_adr", a_mem_adr, 32'd0);
    chk("a_rst_rdata", a_rdata_0 | a_rdata_1 | a_mem_wd, 32'd0);
    chk("b_rst_ctrl", {27'd0, b_done_0, b_done_1, b_mem_we, b_busy, b_owner}, 32'd0);
    chk("b_rst_adr", b_mem_adr | b_mem_wd, 32'd0);
    @(posedge clk); #1;
    reset_a = 1; reset_b = 1;

    // LATENCY=1 single read by port 0
    @(posedge clk); #1;
    a_req_0 = 1; a_we_0 = 0; a_addr_0 = 32'h10;
    exp_a_rd0 = 32'hDEADBEEF;
    qa.push_back(mk(1'b0, exp_a_rd0, exp_a_rd1));
    @(posedge clk);
    @(negedge clk);
    chk("t1_mem_adr", a_mem_adr, 32'h10);
    chk("t1_busy", {31'd0, a_busy}, 32'd1);
    chk("t1_no_early_done", {31'd0, a_done_0}, 32'd0);
    a_req_0 = 0;
    @(negedge clk);
    chk("t1_done_0", {31'd0, a_done_0}, 32'd1);
    chk("t1_rdata_0", a_rdata_0, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_idle", {30'd0, a_busy, a_done_0}, 32'd0);

    // LATENCY=1 both ports from reset: strict alternation 0,1,0,1
    @(posedge clk); #1;
    reset_a = 0;
    exp_a_rd0 = 0; exp_a_rd1 = 0;
    @(posedge clk); #1;
    reset_a = 1;
    a_req_0 = 1; a_req_1 = 1; a_we_0 = 0; a_we_1 = 0;
    a_addr_0 = 32'h100; a_addr_1 = 32'h200;
    qa.push_back(mk(1'b0, mem_f(32'h100), 32'd0));
    qa.push_back(mk(1'b1, mem_f(32'h100), mem_f(32'h200)));
    qa.push_back(mk(1'b0, mem_f(32'h100), mem_f(32'h200)));
    qa.push_back(mk(1'b1, mem_f(32'h100), mem_f(32'h200)));
    exp_a_rd0 = mem_f(32'h100); exp_a_rd1 = mem_f(32'h200);
    seen = 0; cyc = 0; last_cyc = 0; lowcnt = 0;
    while (seen < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!a_busy) lowcnt++;
      if (a_done_0 || a_done_1) begin
        seen++;
        if (seen > 1) begin
          chk("t3_done_gap", cyc - last_cyc, 32'd3);
          chk("t3_busy_low", lowcnt, 32'd1);
        end
        lowcnt = 0;
        last_cyc = cyc;
      end
    end
    a_req_0 = 0; a_req_1 = 0;
    chk("t3_done_count", seen, 32'd4);
    repeat (3) @(negedge clk);
    chk("t3_idle_after", {31'd0, a_busy}, 32'd0);

    // LATENCY=3 port 1 write
    @(posedge clk); #1;
    b_req_1 = 1; b_we_1 = 1; b_addr_1 = 32'h40; b_wdata_1 = 32'h12345678;
    qb.push_back(mk(1'b1, exp_b_rd0, exp_b_rd1));
    @(posedge clk);
    we_cnt = 0; we_at = 0; acc_cnt = 0; done_at = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (b_mem_we) begin
        we_cnt++;
        if (we_at == 0) we_at = k;
        chk("t2_mem_wd", b_mem_wd, 32'h12345678);
      end
      if (b_busy && !b_done_1 && b_mem_adr == 32'h40) acc_cnt++;
      if (b_done_1 && done_at == 0) begin
        done_at = k;
        b_req_1 = 0;
      end
    end
    chk("t2_we_count", we_cnt, 32'd1);
    chk("t2_we_first_cycle", we_at, 32'd1);
    chk("t2_access_cycles", acc_cnt, 32'd3);
    chk("t2_done_cycle", done_at, 32'd4);
    chk("t2_rdata_1_kept", b_rdata_1, 32'd0);

    // LATENCY=3 port 0 read; address and req change mid-access
    @(posedge clk); #1;
    b_req_0 = 1; b_we_0 = 0; b_addr_0 = 32'h30;
    exp_b_rd0 = mem_f(32'h30);
    qb.push_back(mk(1'b0, exp_b_rd0, exp_b_rd1));
    @(posedge clk);
    acc_cnt = 0; done_at = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        b_addr_0 = 32'h99;
        b_req_0 = 0;
      end
      if (b_busy && !b_done_0 && b_mem_adr == 32'h30) acc_cnt++;
      if (b_done_0 && done_at == 0) done_at = k;
    end
    chk("t4_latched_adr", acc_cnt, 32'd3);
    chk("t4_done_cycle", done_at, 32'd4);
    chk("t4_rdata_0", b_rdata_0, mem_f(32'h30));

    // Port 1 read then port 0 write: each rdata stays with its own port
    @(posedge clk); #1;
    b_req_1 = 1; b_we_1 = 0; b_addr_1 = 32'h20;
    exp_b_rd1 = 32'hA5A5A5A5;
    qb.push_back(mk(1'b1, exp_b_rd0, exp_b_rd1));
    b_wait_done(1'b1, at);
    b_req_1 = 0;
    chk("t6_read_latency", at, 32'd5);
    @(posedge clk); #1;
    b_req_0 = 1; b_we_0 = 1; b_addr_0 = 32'h50; b_wdata_0 = 32'h77;
    qb.push_back(mk(1'b0, exp_b_rd0, exp_b_rd1));
    b_wait_done(1'b0, at);
    b_req_0 = 0; b_we_0 = 0;
    chk("t6_write_latency", at, 32'd5);
    chk("t6_rdata_1_kept", b_rdata_1, 32'hA5A5A5A5);
    chk("t6_rdata_0_kept", b_rdata_0, mem_f(32'h30));

    // Asynchronous reset in the 2nd access cycle, then a tie goes to port 0
    @(posedge clk); #1;
    b_req_1 = 1; b_we_1 = 0; b_addr_1 = 32'h60;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t5_busy_before", {30'd0, b_busy, b_owner}, 32'd3);
    b_req_1 = 0;
    #1 reset_b = 0;
    #1;
    chk("t5_async_ctrl", {28'd0, b_busy, b_mem_we, b_owner, b_done_1}, 32'd0);
    chk("t5_async_rdata", b_rdata_1, 32'd0);
    exp_b_rd0 = 0; exp_b_rd1 = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_b = 1;
    b_req_0 = 1; b_req_1 = 1; b_we_0 = 0; b_we_1 = 0;
    b_addr_0 = 32'h70; b_addr_1 = 32'h80;
    exp_b_rd0 = mem_f(32'h70);
    qb.push_back(mk(1'b0, exp_b_rd0, exp_b_rd1));
    b_wait_done(1'b0, at);
    b_req_0 = 0; b_req_1 = 0;
    chk("t5_tie_port0_latency", at, 32'd5);

    repeat (8) @(negedge clk);
    chk("a_queue_drained", qa.size(), 32'd0);
    chk("b_queue_drained", qb.size(), 32'd0);
    chk("b_idle_end", {31'd0, b_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one single-port unified instruction/data memory between two requesters.
- Port 0 is the multicycle MIPS core (fetch and load/store). Port 1 is the program loader/debug DMA.
- Round-robin arbitration with a req/done handshake and a fixed memory access latency. The core stalls its FSM on done_0.

Parameters:
- LATENCY, 1, memory access cycles per transfer; must be >= 1. The counter is sized to $clog2(LATENCY+1) bits.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; 0 resets all state immediately.
- req_0  input  1  core request; held high until done_0.
- we_0  input  1  core write enable; 1 = write, 0 = read.
- addr_0  input  AW  core byte address.
- wdata_0  input  DW  core write data.
- done_0  output  1  one-cycle pulse: core transfer complete.
- rdata_0  output  DW  core read data; valid from done_0 until the next done_0.
- req_1, we_1, addr_1, wdata_1, done_1, rdata_1: same as port 0, for the loader.
- mem_adr  output  AW  memory address.
- mem_wd  output  DW  memory write data.
- mem_we  output  1  memory write strobe.
- mem_rd  input  DW  memory read data; valid by the last ACCESS cycle.
- busy  output  1  high in ACCESS and DONE.
- owner  output  1  port currently granted (0/1); holds the last owner while IDLE.

Behaviour:
- Reset (reset=0): state=IDLE, counter=0, last=1 (so port 0 wins the first tie). All outputs are 0: done_*, rdata_*, mem_adr, mem_wd, mem_we, busy, owner.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, arbitration:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port != last.
  - On grant, register owner, we, addr and wdata from the granted port, set counter=LATENCY-1 and go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - mem_adr and mem_wd are driven from the latched values for every ACCESS cycle.
  - mem_we=1 only in the first ACCESS cycle and only for a write.
  - counter decrements each cycle. When counter==0, capture mem_rd into rdata_<owner> (reads only; writes leave rdata unchanged), set last=owner, go to DONE.
- DONE: done_<owner>=1 for exactly one cycle; mem_we=0; go to IDLE.
- Latency: req sampled at edge N -> ACCESS in cycles N+1..N+LATENCY -> done in cycle N+LATENCY+1. Earliest next grant is sampled in the IDLE cycle N+LATENCY+2.
- Inputs are latched at grant. Later changes to addr, wdata, we or req on either port do not affect the transfer in flight.
- A req dropped mid-transfer does not abort it; done still pulses.
- The non-granted request waits with no timeout. Strict alternation holds while both ports request continuously.
- rdata_x changes only on a read completion for port x. The other port's rdata is never disturbed.
- mem_adr and mem_wd hold their last values in IDLE and DONE. mem_we is 0 outside the first ACCESS cycle.
- Asynchronous reset mid-ACCESS: the transfer is abandoned with no done pulse. All state returns to the reset values immediately, not on the next clock.
- Both req high in the DONE cycle: no effect until IDLE.

Test Plan:
- LATENCY=1; req_0 read at addr 0x10, mem returns 0xDEADBEEF -> mem_adr=0x10 one cycle after sampling, done_0 two cycles after sampling, rdata_0=0xDEADBEEF, owner=0.
- LATENCY=3; req_1 write addr 0x40, data 0x12345678 -> mem_we high exactly 1 cycle, mem_adr=0x40 for 3 cycles, done_1 on the 4th cycle, rdata_1 unchanged (0).
- Both req high from reset, held continuously, LATENCY=1 -> grants in order 0,1,0,1; each done pulse one cycle; busy low one cycle between transfers.
- Port 0 read in flight; change addr_0 to 0x99 and drop req_0 mid-ACCESS -> mem_adr stays at the latched address, done_0 still pulses, rdata_0 = mem_rd of the original address.
- LATENCY=3; assert reset=0 during the 2nd ACCESS cycle -> busy, mem_we and owner go to 0 immediately, no done pulse. After release, a tie grants port 0 first.
- Port 1 read returns 0xA5A5A5A5, then a port 0 write -> rdata_1 stays 0xA5A5A5A5 and rdata_0 is unchanged.
